// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared types and constants for the two-master Wishbone arbiter
package wb_arbiter_pkg;

  // Grant state: which master owns the slave port, if any
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_M0 = 2'd1,
    GRANT_M1 = 2'd2
  } arb_state_e;

  // Tie-break policy selector values for PRIORITY_MODE
  localparam int PRIORITY_FIXED = 0;
  localparam int PRIORITY_RR    = 1;

endpackage

// File: rtl/wb_arbiter_prio.sv
// rtl/wb_arbiter_prio.sv - combinational two-way priority pick for the arbiter
module wb_arbiter_prio
  import wb_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       mode_rr,
  output logic       gnt_valid,
  output logic       gnt_sel
);

  // Pick a master; on a tie, fixed mode favours master 1, round-robin favours
  // whichever master did not hold the bus last.
  always_comb begin
    gnt_valid = |req;
    gnt_sel   = 1'b0;
    case (req)
      2'b01:   gnt_sel = 1'b0;
      2'b10:   gnt_sel = 1'b1;
      2'b11:   gnt_sel = mode_rr ? ~last_grant : 1'b1;
      default: gnt_sel = 1'b0;
    endcase
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - two-master to one-slave pipelined Wishbone arbiter
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int PRIORITY_MODE = PRIORITY_FIXED
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  output logic [31:0] m0_dat_o,
  output logic [31:0] m1_dat_o,
  output logic        m0_ack_o,
  output logic        m1_ack_o,
  output logic        m0_stall_o,
  output logic        m1_stall_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic        s_we_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  output logic [3:0]  s_sel_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_stall_i
);

  localparam logic MODE_RR = (PRIORITY_MODE == PRIORITY_RR);

  arb_state_e state_q;
  logic       last_grant_q;
  logic       gnt_valid;
  logic       gnt_sel;

  wb_arbiter_prio u_prio (
    .req        ({m1_cyc_i, m0_cyc_i}),
    .last_grant (last_grant_q),
    .mode_rr    (MODE_RR),
    .gnt_valid  (gnt_valid),
    .gnt_sel    (gnt_sel)
  );

  // Grant FSM: arbitrate from IDLE, hold the grant while the owner keeps cyc,
  // and hand straight over to a waiting master when the owner releases.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            state_q      <= gnt_sel ? GRANT_M1 : GRANT_M0;
            last_grant_q <= gnt_sel;
          end
        end
        GRANT_M0: begin
          if (!m0_cyc_i) begin
            if (m1_cyc_i) begin
              state_q      <= GRANT_M1;
              last_grant_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        GRANT_M1: begin
          if (!m1_cyc_i) begin
            if (m0_cyc_i) begin
              state_q      <= GRANT_M0;
              last_grant_q <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read data fans out to both masters; only the granted master sees ack.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // Slave-port mux and ack/stall return path; ungranted masters are held stalled.
  always_comb begin
    s_adr_o    = 32'd0;
    s_dat_o    = 32'd0;
    s_we_o     = 1'b0;
    s_stb_o    = 1'b0;
    s_cyc_o    = 1'b0;
    s_sel_o    = 4'd0;
    m0_ack_o   = 1'b0;
    m1_ack_o   = 1'b0;
    m0_stall_o = 1'b1;
    m1_stall_o = 1'b1;
    case (state_q)
      GRANT_M0: begin
        s_adr_o    = m0_adr_i;
        s_dat_o    = m0_dat_i;
        s_we_o     = m0_we_i;
        s_stb_o    = m0_stb_i;
        s_cyc_o    = m0_cyc_i;
        s_sel_o    = m0_sel_i;
        m0_ack_o   = s_ack_i;
        m0_stall_o = s_stall_i;
      end
      GRANT_M1: begin
        s_adr_o    = m1_adr_i;
        s_dat_o    = m1_dat_i;
        s_we_o     = m1_we_i;
        s_stb_o    = m1_stb_i;
        s_cyc_o    = m1_cyc_i;
        s_sel_o    = m1_sel_i;
        m1_ack_o   = s_ack_i;
        m1_stall_o = s_stall_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for wb_arbiter, fixed and round-robin instances
module tb_wb_arbiter;

  typedef logic [138:0] out_t;
  typedef struct packed {
    out_t o0;
    out_t o1;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i, s_dat_i;
  logic        m0_we_i, m0_stb_i, m0_cyc_i, m1_we_i, m1_stb_i, m1_cyc_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        s_ack_i, s_stall_i;

  logic [31:0] m0_dat_o [2];
  logic [31:0] m1_dat_o [2];
  logic        m0_ack_o [2];
  logic        m1_ack_o [2];
  logic        m0_stall_o [2];
  logic        m1_stall_o [2];
  logic [31:0] s_adr_o [2];
  logic [31:0] s_dat_o [2];
  logic        s_we_o [2];
  logic        s_stb_o [2];
  logic        s_cyc_o [2];
  logic [3:0]  s_sel_o [2];
  out_t        act [2];

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   own [2];
  int   last [2];

  always #5 clk_i = ~clk_i;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wb_arbiter #(.PRIORITY_MODE(g)) u_dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .m0_adr_i   (m0_adr_i),
      .m0_dat_i   (m0_dat_i),
      .m0_we_i    (m0_we_i),
      .m0_sel_i   (m0_sel_i),
      .m0_stb_i   (m0_stb_i),
      .m0_cyc_i   (m0_cyc_i),
      .m1_adr_i   (m1_adr_i),
      .m1_dat_i   (m1_dat_i),
      .m1_we_i    (m1_we_i),
      .m1_sel_i   (m1_sel_i),
      .m1_stb_i   (m1_stb_i),
      .m1_cyc_i   (m1_cyc_i),
      .m0_dat_o   (m0_dat_o[g]),
      .m1_dat_o   (m1_dat_o[g]),
      .m0_ack_o   (m0_ack_o[g]),
      .m1_ack_o   (m1_ack_o[g]),
      .m0_stall_o (m0_stall_o[g]),
      .m1_stall_o (m1_stall_o[g]),
      .s_adr_o    (s_adr_o[g]),
      .s_dat_o    (s_dat_o[g]),
      .s_we_o     (s_we_o[g]),
      .s_stb_o    (s_stb_o[g]),
      .s_cyc_o    (s_cyc_o[g]),
      .s_sel_o    (s_sel_o[g]),
      .s_dat_i    (s_dat_i),
      .s_ack_i    (s_ack_i),
      .s_stall_i  (s_stall_i)
    );
    assign act[g] = {s_adr_o[g], s_dat_o[g], s_we_o[g], s_stb_o[g], s_cyc_o[g], s_sel_o[g],
                     m0_dat_o[g], m1_dat_o[g], m0_ack_o[g], m1_ack_o[g],
                     m0_stall_o[g], m1_stall_o[g]};
  end

  // Expected port values for a given bus owner (-1 none, 0 or 1) and current inputs
  function automatic out_t expect_out(int owner);
    logic [31:0] adr, dat;
    logic        we, stb, cyc, a0, a1, st0, st1;
    logic [3:0]  sel;
    adr = 0; dat = 0; we = 0; stb = 0; cyc = 0; sel = 0;
    a0 = 0; a1 = 0; st0 = 1; st1 = 1;
    if (owner == 0) begin
      adr = m0_adr_i; dat = m0_dat_i; we = m0_we_i; stb = m0_stb_i; cyc = m0_cyc_i;
      sel = m0_sel_i; a0 = s_ack_i; st0 = s_stall_i;
    end else if (owner == 1) begin
      adr = m1_adr_i; dat = m1_dat_i; we = m1_we_i; stb = m1_stb_i; cyc = m1_cyc_i;
      sel = m1_sel_i; a1 = s_ack_i; st1 = s_stall_i;
    end
    return {adr, dat, we, stb, cyc, sel, s_dat_i, s_dat_i, a0, a1, st0, st1};
  endfunction

  // Ownership rules applied at a clock edge for both policies
  task automatic advance_model();
    logic c [2];
    c[0] = m0_cyc_i;
    c[1] = m1_cyc_i;
    for (int md = 0; md < 2; md++) begin
      if (!rst_ni) begin
        own[md]  = -1;
        last[md] = 0;
      end else if (own[md] < 0) begin
        if (c[0] && c[1]) own[md] = (md == 1) ? 1 - last[md] : 1;
        else if (c[0])    own[md] = 0;
        else if (c[1])    own[md] = 1;
        if (own[md] >= 0) last[md] = own[md];
      end else if (!c[own[md]]) begin
        if (c[1 - own[md]]) begin
          own[md]  = 1 - own[md];
          last[md] = own[md];
        end else begin
          own[md] = -1;
        end
      end
    end
  endtask

  // One bus cycle: record expectations for the inputs now applied, then clock
  task automatic step();
    exp_t e;
    e.o0 = expect_out(own[0]);
    e.o1 = expect_out(own[1]);
    sb.push_back(e);
    @(posedge clk_i);
    advance_model();
    #1;
  endtask

  // Monitor: compare DUT outputs against the oldest pending expectation
  always @(negedge clk_i) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      if (act[0] !== e.o0) begin
        n_err++;
        $display("FAIL fixed_prio t=%0t actual=%h required=%h", $time, act[0], e.o0);
      end
      n_cmp++;
      if (act[1] !== e.o1) begin
        n_err++;
        $display("FAIL round_robin t=%0t actual=%h required=%h", $time, act[1], e.o1);
      end
    end
  end

  initial begin
    int hold [2];
    int gap [2];
    logic mc [2];
    own[0] = -1; own[1] = -1; last[0] = 0; last[1] = 0;
    hold[0] = 0; hold[1] = 0; gap[0] = 0; gap[1] = 0; mc[0] = 0; mc[1] = 0;

    rst_ni = 0;
    m0_adr_i = 32'h0000_1000; m0_dat_i = 32'h1111_0000; m0_we_i = 0; m0_sel_i = 4'hF;
    m0_stb_i = 1; m0_cyc_i = 1;
    m1_adr_i = 32'h0000_2000; m1_dat_i = 32'h2222_0000; m1_we_i = 1; m1_sel_i = 4'h3;
    m1_stb_i = 0; m1_cyc_i = 0;
    s_dat_i = 32'h0; s_ack_i = 0; s_stall_i = 0;
    @(posedge clk_i);
    #1;

    // Reset held with m0 requesting, then release and a single read
    step(); step();
    rst_ni = 1;
    step(); step();
    s_ack_i = 1; s_dat_i = 32'hDEAD_BEEF;
    step();
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    step();

    // Simultaneous request, then handoff without an idle bubble
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    step(); step(); step();
    m1_cyc_i = 0; m1_stb_i = 0;
    step(); step();
    m0_cyc_i = 0; m0_stb_i = 0;
    step();

    // Slave stall while master 1 owns the bus
    m1_cyc_i = 1; m1_stb_i = 1; m0_cyc_i = 1; m0_stb_i = 1;
    step();
    s_stall_i = 1;
    step(); step(); step();
    s_stall_i = 0;
    m1_cyc_i = 0; m1_stb_i = 0;
    step();

    // Reset while m0 waits on an ack; a late ack must not be forwarded
    step();
    rst_ni = 0;
    step();
    rst_ni = 1; m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 1;
    step();
    s_ack_i = 0;
    step();

    // Randomised traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (mc[m]) begin
          if (hold[m] == 0) begin
            mc[m]  = 0;
            gap[m] = $urandom_range(1, 3);
          end else begin
            hold[m]--;
          end
        end else if (gap[m] > 0) begin
          gap[m]--;
        end else if ($urandom_range(0, 2) == 0) begin
          mc[m]   = 1;
          hold[m] = $urandom_range(0, 5);
        end
      end
      rst_ni    = ($urandom_range(0, 99) != 0);
      m0_cyc_i  = mc[0];
      m1_cyc_i  = mc[1];
      m0_stb_i  = mc[0] & $urandom_range(0, 1);
      m1_stb_i  = mc[1] & $urandom_range(0, 1);
      m0_adr_i  = $urandom; m0_dat_i = $urandom; m0_we_i = $urandom_range(0, 1);
      m0_sel_i  = $urandom_range(0, 15);
      m1_adr_i  = $urandom; m1_dat_i = $urandom; m1_we_i = $urandom_range(0, 1);
      m1_sel_i  = $urandom_range(0, 15);
      s_dat_i   = $urandom;
      s_ack_i   = $urandom_range(0, 1);
      s_stall_i = ($urandom_range(0, 3) == 0);
      step();
    end

    for (int k = 0; k < 10 && sb.size() > 0; k++) begin
      @(negedge clk_i);
      #1;
    end
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
